// File: rtl/invader_fleet_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | invader_fleet_renderer                                                     |
// | Moves an alien fleet grid one step per MOVE_FRAMES frames, tracks kills,   |
// | and renders alive aliens as a 1-cycle registered pixel request.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module invader_fleet_renderer #(
  parameter int         COLS         = 8,
  parameter int         ROWS         = 4,
  parameter int         PITCH_X      = 64,
  parameter int         PITCH_Y      = 32,
  parameter int         ALIEN_W      = 48,
  parameter int         ALIEN_H      = 24,
  parameter int         START_X      = 64,
  parameter int         START_Y      = 48,
  parameter int         STEP_X       = 8,
  parameter int         STEP_Y       = 16,
  parameter int         MOVE_FRAMES  = 30,
  parameter int         LEFT_LIMIT   = 16,
  parameter int         RIGHT_LIMIT  = 624,
  parameter int         BOTTOM_LIMIT = 400,
  parameter logic [7:0] ALIEN_RGB    = 8'h1C
) (
  input  logic        vga_clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        blank_n,
  input  logic        VS,
  input  logic        game_restart,
  input  logic        kill_valid,
  input  logic [2:0]  kill_col,
  input  logic [1:0]  kill_row,
  output logic        draw_req,
  output logic [7:0]  rgb,
  output logic [10:0] fleet_x,
  output logic [10:0] fleet_y,
  output logic [5:0]  alive_count,
  output logic        fleet_cleared,
  output logic        fleet_landed
);

  localparam int          c_N      = COLS * ROWS;
  localparam int          c_FW     = (COLS - 1) * PITCH_X + ALIEN_W;
  localparam int          c_FH     = (ROWS - 1) * PITCH_Y + ALIEN_H;
  localparam int          c_PX_SH  = $clog2(PITCH_X);
  localparam int          c_PY_SH  = $clog2(PITCH_Y);
  localparam int          c_FCW    = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
  localparam logic [10:0] c_PX_MASK = 11'(PITCH_X - 1);
  localparam logic [10:0] c_PY_MASK = 11'(PITCH_Y - 1);

  typedef enum logic [1:0] {
    S_MOVE_RIGHT = 2'd0,
    S_MOVE_LEFT  = 2'd1,
    S_HALT       = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_vs;
  logic [c_FCW-1:0] r_frame_cnt;
  logic [10:0]      r_fleet_x;
  logic [10:0]      r_fleet_y;
  logic [c_N-1:0]   r_alive;
  logic [5:0]       r_alive_count;
  logic             r_cleared;
  logic             r_landed;
  logic             r_draw;
  logic [7:0]       r_rgb;

  logic             w_frame_tick;
  logic             w_last_frame;
  logic             w_right_ok;
  logic             w_left_ok;
  logic [10:0]      w_y_down;
  logic             w_land;
  logic [c_N-1:0]   w_kill_mask;
  logic [c_N-1:0]   w_alive_next;
  logic [c_N-1:0]   w_hit_vec;
  logic [10:0]      w_rel_x;
  logic [10:0]      w_rel_y;
  logic [10:0]      w_col;
  logic [10:0]      w_row;
  logic             w_in_cell;
  logic             w_draw;

  assign w_frame_tick = r_vs && !VS;
  assign w_last_frame = (r_frame_cnt == c_FCW'(MOVE_FRAMES - 1));
  assign w_right_ok   = (32'(r_fleet_x) + c_FW + STEP_X) <= RIGHT_LIMIT;
  assign w_left_ok    = 32'(r_fleet_x) >= (LEFT_LIMIT + STEP_X);
  assign w_y_down     = r_fleet_y + 11'(STEP_Y);
  assign w_land       = (32'(w_y_down) + c_FH) >= BOTTOM_LIMIT;

  always_ff @(posedge vga_clk or negedge resetN) begin
    if (!resetN) r_vs <= 1'b1;
    else         r_vs <= VS;
  end

  // Movement FSM: a lost fleet or a landed fleet parks in S_HALT until restart.
  always_ff @(posedge vga_clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_MOVE_RIGHT;
      r_frame_cnt <= '0;
      r_fleet_x   <= 11'(START_X);
      r_fleet_y   <= 11'(START_Y);
      r_cleared   <= 1'b0;
      r_landed    <= 1'b0;
    end else if (game_restart) begin
      r_state     <= S_MOVE_RIGHT;
      r_frame_cnt <= '0;
      r_fleet_x   <= 11'(START_X);
      r_fleet_y   <= 11'(START_Y);
      r_cleared   <= 1'b0;
      r_landed    <= 1'b0;
    end else if (r_state != S_HALT) begin
      if (r_alive_count == 6'd0) begin
        r_state   <= S_HALT;
        r_cleared <= 1'b1;
      end else if (w_frame_tick) begin
        r_frame_cnt <= w_last_frame ? '0 : r_frame_cnt + 1'b1;
        if (w_last_frame) begin
          case (r_state)
            S_MOVE_RIGHT: begin
              if (w_right_ok) begin
                r_fleet_x <= r_fleet_x + 11'(STEP_X);
              end else begin
                r_fleet_y <= w_y_down;
                r_landed  <= w_land;
                r_state   <= w_land ? S_HALT : S_MOVE_LEFT;
              end
            end
            S_MOVE_LEFT: begin
              if (w_left_ok) begin
                r_fleet_x <= r_fleet_x - 11'(STEP_X);
              end else begin
                r_fleet_y <= w_y_down;
                r_landed  <= w_land;
                r_state   <= w_land ? S_HALT : S_MOVE_RIGHT;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign w_rel_x   = pixelX - r_fleet_x;
  assign w_rel_y   = pixelY - r_fleet_y;
  assign w_col     = w_rel_x >> c_PX_SH;
  assign w_row     = w_rel_y >> c_PY_SH;
  assign w_in_cell = (pixelX >= r_fleet_x) && (pixelY >= r_fleet_y) &&
                     (32'(w_col) < COLS) && (32'(w_row) < ROWS) &&
                     (32'(w_rel_x & c_PX_MASK) < ALIEN_W) &&
                     (32'(w_rel_y & c_PY_MASK) < ALIEN_H);

  // One decode cell per alien: kill select and pixel hit share the grid.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int c_IDX = r * COLS + c;
      assign w_kill_mask[c_IDX] = kill_valid && (32'(kill_row) == r) && (32'(kill_col) == c);
      assign w_hit_vec[c_IDX]   = r_alive[c_IDX] && (32'(w_row) == r) && (32'(w_col) == c);
    end
  end

  assign w_alive_next = game_restart ? {c_N{1'b1}} : (r_alive & ~w_kill_mask);
  assign w_draw       = blank_n && w_in_cell && (|w_hit_vec);

  always_ff @(posedge vga_clk or negedge resetN) begin
    if (!resetN) begin
      r_alive       <= {c_N{1'b1}};
      r_alive_count <= 6'(c_N);
    end else begin
      r_alive       <= w_alive_next;
      r_alive_count <= 6'($countones(w_alive_next));
    end
  end

  always_ff @(posedge vga_clk or negedge resetN) begin
    if (!resetN) begin
      r_draw <= 1'b0;
      r_rgb  <= 8'h00;
    end else begin
      r_draw <= w_draw;
      r_rgb  <= w_draw ? ALIEN_RGB : 8'h00;
    end
  end

  assign draw_req      = r_draw;
  assign rgb           = r_rgb;
  assign fleet_x       = r_fleet_x;
  assign fleet_y       = r_fleet_y;
  assign alive_count   = r_alive_count;
  assign fleet_cleared = r_cleared;
  assign fleet_landed  = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_invader_fleet_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_invader_fleet_renderer                                                  |
// | Scoreboard bench: stimulus queues expectations, a monitor compares them.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_invader_fleet_renderer;

  logic        vga_clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        blank_n = 1'b0;
  logic        VS = 1'b1;
  logic        game_restart = 1'b0;
  logic        kill_valid = 1'b0;
  logic [2:0]  kill_col = '0;
  logic [1:0]  kill_row = '0;
  logic        draw_req;
  logic [7:0]  rgb;
  logic [10:0] fleet_x;
  logic [10:0] fleet_y;
  logic [5:0]  alive_count;
  logic        fleet_cleared;
  logic        fleet_landed;

  invader_fleet_renderer dut (
    .vga_clk       (vga_clk),
    .resetN        (resetN),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .blank_n       (blank_n),
    .VS            (VS),
    .game_restart  (game_restart),
    .kill_valid    (kill_valid),
    .kill_col      (kill_col),
    .kill_row      (kill_row),
    .draw_req      (draw_req),
    .rgb           (rgb),
    .fleet_x       (fleet_x),
    .fleet_y       (fleet_y),
    .alive_count   (alive_count),
    .fleet_cleared (fleet_cleared),
    .fleet_landed  (fleet_landed)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef enum int {K_DRAW, K_RGB, K_FX, K_FY, K_ALIVE, K_CLR, K_LAND} kind_e;
  typedef struct {
    kind_e kind;
    int    exp;
    int    due;
  } item_t;

  item_t q[$];
  item_t it;
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;
  bit    drained = 1'b0;
  int    act;

  function automatic int actual(kind_e k);
    case (k)
      K_DRAW:  return int'(draw_req);
      K_RGB:   return int'(rgb);
      K_FX:    return int'(fleet_x);
      K_FY:    return int'(fleet_y);
      K_ALIVE: return int'(alive_count);
      K_CLR:   return int'(fleet_cleared);
      default: return int'(fleet_landed);
    endcase
  endfunction

  function automatic string kname(kind_e k);
    case (k)
      K_DRAW:  return "draw_req";
      K_RGB:   return "rgb";
      K_FX:    return "fleet_x";
      K_FY:    return "fleet_y";
      K_ALIVE: return "alive_count";
      K_CLR:   return "fleet_cleared";
      default: return "fleet_landed";
    endcase
  endfunction

  always @(negedge vga_clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      it  = q.pop_front();
      act = actual(it.kind);
      checks++;
      if (act != it.exp) begin
        errors++;
        $display("FAIL %s @cycle %0d: got %0d expected %0d", kname(it.kind), cyc, act, it.exp);
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
    end
  end

  task automatic push(kind_e k, int e, int d);
    item_t n;
    n.kind = k;
    n.exp  = e;
    n.due  = d;
    q.push_back(n);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame();
    VS = 1'b0;
    tick();
    VS = 1'b1;
    tick();
  endtask

  task automatic steps(int n);
    repeat (30 * n) frame();
  endtask

  task automatic check_state(int fx, int fy, int alive, int clr, int land);
    push(K_FX, fx, cyc);
    push(K_FY, fy, cyc);
    push(K_ALIVE, alive, cyc);
    push(K_CLR, clr, cyc);
    push(K_LAND, land, cyc);
  endtask

  task automatic pix(int x, int y, bit b, bit e);
    pixelX  = 11'(x);
    pixelY  = 11'(y);
    blank_n = b;
    push(K_DRAW, int'(e), cyc + 1);
    push(K_RGB, e ? 28 : 0, cyc + 1);
    tick();
  endtask

  task automatic kill(int c, int r, int exp_alive);
    kill_col   = 3'(c);
    kill_row   = 2'(r);
    kill_valid = 1'b1;
    push(K_ALIVE, exp_alive, cyc + 1);
    tick();
    kill_valid = 1'b0;
  endtask

  task automatic restart();
    game_restart = 1'b1;
    tick();
    game_restart = 1'b0;
    check_state(64, 48, 32, 0, 0);
  endtask

  initial begin
    int n;
    tick();
    tick();
    push(K_DRAW, 0, cyc);
    push(K_RGB, 0, cyc);
    check_state(64, 48, 32, 0, 0);
    tick();
    resetN = 1'b1;
    tick();

    // Rendering at the start position: hits, gap, blanking and fleet edges.
    pix(64, 48, 1'b1, 1'b1);
    pix(112, 48, 1'b1, 1'b0);
    pix(559, 167, 1'b1, 1'b1);
    pix(64, 48, 1'b0, 1'b0);
    pix(63, 48, 1'b1, 1'b0);
    pix(64, 72, 1'b1, 1'b0);
    pix(576, 48, 1'b1, 1'b0);
    blank_n = 1'b0;

    // Frame cadence: 29 edges hold, the 30th steps.
    repeat (29) frame();
    check_state(64, 48, 32, 0, 0);
    frame();
    check_state(72, 48, 32, 0, 0);
    steps(7);
    check_state(128, 48, 32, 0, 0);
    steps(1);
    check_state(128, 64, 32, 0, 0);
    steps(1);
    check_state(120, 64, 32, 0, 0);

    // Kills, repeat kill, then wipe the fleet.
    kill(0, 0, 31);
    pix(120, 64, 1'b1, 1'b0);
    pix(184, 64, 1'b1, 1'b1);
    blank_n = 1'b0;
    kill(0, 0, 31);
    n = 31;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (r != 0 || c != 0) begin
          n--;
          kill(c, r, n);
        end
      end
    end
    repeat (3) tick();
    check_state(120, 64, 0, 1, 0);
    steps(1);
    check_state(120, 64, 0, 1, 0);
    restart();

    // March to the bottom.
    steps(16);
    check_state(72, 64, 32, 0, 0);
    steps(202);
    check_state(128, 272, 32, 0, 0);
    steps(1);
    check_state(128, 288, 32, 0, 1);
    steps(2);
    check_state(128, 288, 32, 0, 1);
    restart();

    // Restart beats a simultaneous kill.
    kill(0, 0, 31);
    game_restart = 1'b1;
    kill_valid   = 1'b1;
    kill_col     = 3'd1;
    push(K_ALIVE, 32, cyc + 1);
    tick();
    game_restart = 1'b0;
    kill_valid   = 1'b0;

    // Asynchronous reset in the middle of a step interval.
    steps(1);
    repeat (5) frame();
    kill(2, 1, 31);
    pix(72, 48, 1'b1, 1'b1);
    tick();
    resetN = 1'b0;
    #1;
    push(K_DRAW, 0, cyc);
    push(K_RGB, 0, cyc);
    check_state(64, 48, 32, 0, 0);
    tick();
    resetN  = 1'b1;
    blank_n = 1'b0;
    tick();
    repeat (29) frame();
    check_state(64, 48, 32, 0, 0);
    frame();
    check_state(72, 48, 32, 0, 0);

    tick();
    done = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
